fault_injection_top: RTL and testbench
======================================

FAULT_INJECTION_TOP -- requirements
Module: fault_injection_top

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 The block SHALL have parameter BAUD, default 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (868 at defaults).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock (all logic on rising edge).
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port uart_rx_pin, input, 1 bit, asynchronous UART RX line, 8N1, LSB first, idle high.
REQ-006 The block SHALL have port trigger_in, input, 1 bit, asynchronous trigger; rising edge starts a glitch sequence when armed.
REQ-007 The block SHALL have port fault_out, output, 1 bit, registered glitch pulse output, active high.

Function
REQ-008 uart_rx_pin and trigger_in SHALL each pass through a 2-flop synchronizer before use.
REQ-009 UART receiver: falling edge in idle starts reception; start bit re-checked low at CLKS_PER_BIT/2, else abort to idle.
REQ-010 Data bits SHALL be sampled at the middle of each bit period, LSB first; stop bit sampled mid-bit.
REQ-011 A stop bit sampled low SHALL discard the byte (framing error), with no byte-valid pulse.
REQ-012 A valid byte SHALL produce a one-cycle rx_valid with rx_data[7:0].
REQ-013 Command parser states: CMD_IDLE, CMD_ARG. In CMD_IDLE: 0xA0/0xA1/0xA2 record the target and go to CMD_ARG; 0x01 sets armed; 0x00 clears armed and aborts any sequence; other bytes are ignored.
REQ-014 In CMD_ARG the next valid byte, of any value, SHALL be written to the target register (0xA0 offset, 0xA1 width, 0xA2 repeat), returning to CMD_IDLE.
REQ-015 offset, width and repeat SHALL each be 8-bit unsigned registers.
REQ-016 Glitch FSM states: G_IDLE, G_DELAY, G_HIGH, G_LOW.
REQ-017 In G_IDLE with armed=1, a synchronized trigger rising edge SHALL latch offset/width/repeat into working counters and start the sequence; armed SHALL clear (one-shot).
REQ-018 Timing: the first fault_out rise SHALL occur exactly offset+3 clock edges after the first edge sampling trigger_in high; offset=0 gives a 3-cycle latency.
REQ-019 fault_out SHALL stay high exactly width cycles, then low exactly width cycles, per pulse, for repeat pulses; after the last high phase, go directly to G_IDLE with fault_out low.
REQ-020 If width=0 or repeat=0, the sequence SHALL complete with no pulse, return to G_IDLE, and armed SHALL still be cleared.
REQ-021 Trigger edges while not armed or not in G_IDLE SHALL be ignored.
REQ-022 Register writes during a sequence SHALL affect only the next sequence.
REQ-023 Command 0x00 mid-sequence SHALL force fault_out low on the next clock edge and return to G_IDLE.
REQ-024 Command 0x01 during a sequence SHALL set armed, effective for the next trigger after returning to G_IDLE.

Reset
REQ-025 While rst_n=0, all state SHALL be cleared: fault_out=0, armed=0, offset=width=repeat=0, parser CMD_IDLE, glitch FSM G_IDLE, UART idle, synchronizers=1 for RX and 0 for trigger.
REQ-026 Reset mid-sequence or mid-byte SHALL abort immediately; the partial byte is lost.

Structure
REQ-027 A shared package fault_injection_pkg SHALL hold command codes (0xA0, 0xA1, 0xA2, 0x01, 0x00) and the parser and glitch FSM state enums.
REQ-028 UART reception SHALL be a sub-module uart_rx (params CLKS_PER_BIT; ports clk, rst_n, rx, rx_data, rx_valid); parser and glitch FSM stay in the top.

Verification
REQ-029 Send A0 14, A1 0A, A2 03, 01; pulse trigger_in for 20 ns -> fault_out: first rise at offset+3=23 cycles, then 3 pulses of 10 cycles high / 10 low, then low.
REQ-030 Trigger without 01 (disarmed) -> fault_out stays 0; a second trigger after a completed sequence -> no pulse (one-shot).
REQ-031 Offset 0, width 1, repeat 1 -> single 1-cycle pulse 3 cycles after trigger; repeat 0 -> no pulse, armed cleared.
REQ-032 Byte with stop bit low, then byte 0x01 -> first byte ignored, armed set.
REQ-033 Send 00 during the G_HIGH phase of the REQ-029 setup -> fault_out low on the next cycle, no further pulses.
REQ-034 Assert rst_n low mid-sequence -> fault_out=0 immediately and all registers 0.

Source files
------------

// File: rtl/fault_injection_pkg.sv
// fault_injection_pkg: command codes and state encodings shared by the fault injector
package fault_injection_pkg;
  localparam logic [7:0] CMD_OFFSET = 8'hA0;
  localparam logic [7:0] CMD_WIDTH  = 8'hA1;
  localparam logic [7:0] CMD_REPEAT = 8'hA2;
  localparam logic [7:0] CMD_ARM    = 8'h01;
  localparam logic [7:0] CMD_DISARM = 8'h00;
  typedef enum logic {CMD_IDLE, CMD_ARG} cmd_state_t;
  typedef enum logic [1:0] {G_IDLE, G_DELAY, G_HIGH, G_LOW} glitch_state_t;
  typedef enum logic [1:0] {TGT_OFFSET, TGT_WIDTH, TGT_REPEAT} target_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/fault_injection_top_uart_rx.sv
// uart_rx: 8N1 receiver on an already-synchronized line, mid-bit sampling
module uart_rx
  import fault_injection_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          rx_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_prev  <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_prev  <= rx;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx) state <= RX_START;
        end
        RX_START: begin
          cnt <= (cnt == HALF) ? '0 : cnt + 1'b1;
          bit_idx <= '0;
          if (cnt == HALF) state <= rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          cnt <= (cnt == FULL) ? '0 : cnt + 1'b1;
          if (cnt == FULL) begin
            rx_data <= {rx, rx_data[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        default: begin
          cnt <= (cnt == FULL) ? '0 : cnt + 1'b1;
          if (cnt == FULL) begin
            rx_valid <= rx;
            state    <= RX_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/fault_injection_top.sv
// fault_injection_top: UART-configured, trigger-launched glitch pulse generator
module fault_injection_top
  import fault_injection_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx_pin,
  input  logic trigger_in,
  output logic fault_out
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  logic [1:0]    rx_sync, trig_sync;
  logic          trig_prev, trig_rise;
  logic [7:0]    rx_data;
  logic          rx_valid;
  cmd_state_t    cmd_state;
  target_t       target;
  logic [7:0]    offset, width, repeats;
  logic          armed, idle_byte, abort, arm, start, is_cfg;
  glitch_state_t g_state;
  logic [7:0]    cnt, w_width, w_rep;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync   <= 2'b11;
      trig_sync <= 2'b00;
      trig_prev <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], uart_rx_pin};
      trig_sync <= {trig_sync[0], trigger_in};
      trig_prev <= trig_sync[1];
    end
  end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx_sync[1]),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );
  always_comb begin
    trig_rise = trig_sync[1] & ~trig_prev;
    idle_byte = rx_valid && cmd_state == CMD_IDLE;
    abort     = idle_byte && rx_data == CMD_DISARM;
    arm       = idle_byte && rx_data == CMD_ARM;
    is_cfg    = rx_data == CMD_OFFSET || rx_data == CMD_WIDTH || rx_data == CMD_REPEAT;
    start     = g_state == G_IDLE && armed && trig_rise && !abort;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_state <= CMD_IDLE;
      target    <= TGT_OFFSET;
      offset    <= '0;
      width     <= '0;
      repeats   <= '0;
      armed     <= 1'b0;
    end else begin
      if (rx_valid && cmd_state == CMD_ARG) begin
        cmd_state <= CMD_IDLE;
        if (target == TGT_OFFSET) offset <= rx_data;
        if (target == TGT_WIDTH) width <= rx_data;
        if (target == TGT_REPEAT) repeats <= rx_data;
      end else if (idle_byte && is_cfg) begin
        cmd_state <= CMD_ARG;
        target    <= rx_data == CMD_OFFSET ? TGT_OFFSET : rx_data == CMD_WIDTH ? TGT_WIDTH : TGT_REPEAT;
      end
      armed <= abort ? 1'b0 : arm ? 1'b1 : start ? 1'b0 : armed;
    end
  end
  // Working copies keep register writes during a run from affecting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_state   <= G_IDLE;
      cnt       <= '0;
      w_width   <= '0;
      w_rep     <= '0;
      fault_out <= 1'b0;
    end else if (abort) begin
      g_state   <= G_IDLE;
      fault_out <= 1'b0;
    end else begin
      case (g_state)
        G_IDLE: if (start) begin
          cnt     <= offset;
          w_width <= width;
          w_rep   <= repeats;
          g_state <= G_DELAY;
        end
        G_DELAY: begin
          cnt <= (cnt == 8'd0) ? w_width - 8'd1 : cnt - 8'd1;
          if (cnt == 8'd0) begin
            g_state   <= (w_width == 8'd0 || w_rep == 8'd0) ? G_IDLE : G_HIGH;
            fault_out <= w_width != 8'd0 && w_rep != 8'd0;
          end
        end
        G_HIGH: begin
          cnt <= (cnt == 8'd0) ? w_width - 8'd1 : cnt - 8'd1;
          if (cnt == 8'd0) begin
            fault_out <= 1'b0;
            w_rep     <= w_rep - 8'd1;
            g_state   <= (w_rep == 8'd1) ? G_IDLE : G_LOW;
          end
        end
        default: begin
          cnt <= (cnt == 8'd0) ? w_width - 8'd1 : cnt - 8'd1;
          if (cnt == 8'd0) begin
            fault_out <= 1'b1;
            g_state   <= G_HIGH;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fault_injection_top.sv
// tb_fault_injection_top: directed and randomized checks against a waveform-level model
module tb_fault_injection_top;
  localparam int CPB = 10;
  logic clk = 1'b0, rst_n = 1'b0, uart_rx_pin = 1'b1, trigger_in = 1'b0;
  logic fault_out;
  int   checks = 0, errors = 0;
  int   m_off = 0, m_wid = 0, m_rep = 0, m_tgt = 0;
  bit   m_armed = 0;

  fault_injection_top #(.CLK_FREQ_HZ(100_000_000), .BAUD(10_000_000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx_pin (uart_rx_pin),
    .trigger_in  (trigger_in),
    .fault_out   (fault_out)
  );

  always #5 clk = ~clk;

  initial begin
    #600us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    uart_rx_pin = 1'b0;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      repeat (CPB) @(posedge clk); #1;
    end
    uart_rx_pin = stop;
    repeat (CPB) @(posedge clk); #1;
    uart_rx_pin = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_byte(b, 1'b1);
    if (m_tgt != 0) begin
      if (m_tgt == 1) m_off = b;
      if (m_tgt == 2) m_wid = b;
      if (m_tgt == 3) m_rep = b;
      m_tgt = 0;
    end else if (b == 8'hA0) m_tgt = 1;
    else if (b == 8'hA1) m_tgt = 2;
    else if (b == 8'hA2) m_tgt = 3;
    else if (b == 8'h01) m_armed = 1;
    else if (b == 8'h00) m_armed = 0;
  endtask

  task automatic configure(input int off, input int wid, input int rep, input bit do_arm);
    send_cmd(8'hA0); send_cmd(8'(off));
    send_cmd(8'hA1); send_cmd(8'(wid));
    send_cmd(8'hA2); send_cmd(8'(rep));
    if (do_arm) send_cmd(8'h01);
  endtask

  task automatic run_trigger(input string tag);
    int first, period, total;
    bit act, exp;
    first  = m_off + 3;
    period = 2 * m_wid;
    total  = first + period * m_rep + 6;
    act    = m_armed && m_wid > 0 && m_rep > 0;
    @(posedge clk); #1;
    trigger_in = 1'b1;
    for (int k = 0; k <= total; k++) begin
      @(posedge clk); #1;
      if (k == 1) trigger_in = 1'b0;
      exp = 1'b0;
      if (act && k >= first && (k - first) < period * m_rep)
        exp = ((k - first) % period) < m_wid;
      chk(tag, {31'd0, fault_out}, {31'd0, exp});
    end
    m_armed = 0;
    chk("armed_after_trigger", {31'd0, dut.armed}, {31'd0, m_armed});
  endtask

  initial begin
    int off, wid, rep, seen;
    logic [7:0] junk;
    bit hit;
    repeat (3) @(posedge clk); #1;
    chk("reset_fault", {31'd0, fault_out}, 0);
    chk("reset_armed", {31'd0, dut.armed}, 0);
    chk("reset_offset", {24'd0, dut.offset}, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("idle_fault", {31'd0, fault_out}, 0);

    configure(8'h14, 8'h0A, 8'h03, 1);
    chk("cfg_offset", {24'd0, dut.offset}, m_off);
    chk("cfg_width", {24'd0, dut.width}, m_wid);
    chk("cfg_repeat", {24'd0, dut.repeats}, m_rep);
    chk("cfg_armed", {31'd0, dut.armed}, {31'd0, m_armed});
    run_trigger("seq_basic");
    run_trigger("seq_oneshot");

    configure(0, 1, 1, 1);
    run_trigger("seq_min");
    send_cmd(8'hA2); send_cmd(8'h00); send_cmd(8'h01);
    run_trigger("seq_rep0");

    send_byte(8'hA0, 1'b0);
    send_cmd(8'h01);
    chk("framing_armed", {31'd0, dut.armed}, {31'd0, m_armed});
    chk("framing_offset", {24'd0, dut.offset}, m_off);
    run_trigger("seq_after_framing");

    for (int it = 0; it < 8; it++) begin
      off = $urandom_range(0, 30);
      wid = $urandom_range(0, 5);
      rep = $urandom_range(0, 4);
      junk = 8'($urandom_range(2, 255));
      if (junk >= 8'hA0 && junk <= 8'hA2) junk = 8'h55;
      configure(off, wid, rep, $urandom_range(0, 3) != 0);
      send_cmd(junk);
      run_trigger("seq_random");
    end

    configure(5, 200, 3, 1);
    @(posedge clk); #1;
    trigger_in = 1'b1;
    repeat (2) @(posedge clk); #1;
    trigger_in = 1'b0;
    m_armed = 0;
    seen = 0;
    while (!fault_out && seen < 50) begin @(posedge clk); #1; seen++; end
    chk("abort_rise", {31'd0, fault_out}, 1);
    fork send_cmd(8'h00); join_none
    seen = 0;
    while (!dut.rx_valid && seen < 300) begin @(posedge clk); #1; seen++; end
    chk("abort_rx_seen", {31'd0, dut.rx_valid}, 1);
    chk("abort_before", {31'd0, fault_out}, 1);
    @(posedge clk); #1;
    chk("abort_next", {31'd0, fault_out}, 0);
    wait fork;
    hit = 0;
    for (int k = 0; k < 700; k++) begin @(posedge clk); #1; hit |= fault_out; end
    chk("abort_stays_low", {31'd0, hit}, 0);
    chk("abort_armed", {31'd0, dut.armed}, 0);

    configure(5, 4, 5, 1);
    @(posedge clk); #1;
    trigger_in = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) trigger_in = 1'b0;
    end
    chk("reset_pre_high", {31'd0, fault_out}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_fault_async", {31'd0, fault_out}, 0);
    chk("reset_offset_mid", {24'd0, dut.offset}, 0);
    chk("reset_width_mid", {24'd0, dut.width}, 0);
    chk("reset_repeat_mid", {24'd0, dut.repeats}, 0);
    chk("reset_armed_mid", {31'd0, dut.armed}, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    m_off = 0; m_wid = 0; m_rep = 0; m_armed = 0; m_tgt = 0;
    hit = 0;
    for (int k = 0; k < 50; k++) begin @(posedge clk); #1; hit |= fault_out; end
    chk("reset_stays_low", {31'd0, hit}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
